el2_lsu_clken_ctrl: RTL



---
 rtl/el2_lsu_clken_ctrl.sv | 152 +++++++++++++++
 1 files changed

// File: rtl/el2_lsu_clken_ctrl.sv
// el2_lsu_clken_ctrl
// ------------------
// Clock-enable controller for the LSU clock domain. It produces NCH
// independent clock enables that drive the LSU pipe, store buffer and bus
// buffer clock headers. Each channel keeps its enable asserted for a
// programmable number of cycles after its activity request drops. Channels
// selected in BUS_QUAL are gated by the bus clock enable, and their hold
// counters only advance on bus cycles. A halt/drain handshake lets the TLU
// quiesce every LSU clock before a debug halt.
//
// Parameters:
//   NCH       number of clock-enable channels (1..32)
//   HOLD_W    width of each hold counter (max hold 2^HOLD_W-1 cycles)
//   BUS_QUAL  per-channel mask, 1 = channel qualified by bus clock enable
//
// Ports:
//   clk             core clock
//   rst             asynchronous reset, active-high
//   i_scan_mode     forces every enable on
//   i_clk_override  forces enables on (bus qualification still applies)
//   i_req           per-channel activity request
//   i_hold_cfg      per-channel hold length, channel i at [i*HOLD_W +: HOLD_W]
//   i_bus_clk_en    bus clock enable
//   i_halt_req      level request to quiesce all channels
//   o_halt_ack      all channels drained and the block is halted
//   o_clken         per-channel clock enable
//   o_free_clken    free-running domain enable
//   o_ch_busy       per-channel hold counter is nonzero

module el2_lsu_clken_ctrl #(
  parameter int             NCH      = 8,
  parameter int             HOLD_W   = 3,
  parameter logic [NCH-1:0] BUS_QUAL = '0
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  i_scan_mode,
  input  logic                  i_clk_override,
  input  logic [NCH-1:0]        i_req,
  input  logic [NCH*HOLD_W-1:0] i_hold_cfg,
  input  logic                  i_bus_clk_en,
  input  logic                  i_halt_req,
  output logic                  o_halt_ack,
  output logic [NCH-1:0]        o_clken,
  output logic                  o_free_clken,
  output logic [NCH-1:0]        o_ch_busy
);

  typedef enum logic [1:0] {
    RUN    = 2'd0,
    DRAIN  = 2'd1,
    HALTED = 2'd2
  } state_t;

  state_t            r_state;
  state_t            w_stateNext;
  logic [HOLD_W-1:0] r_cnt     [NCH];
  logic [HOLD_W-1:0] w_cntNext [NCH];
  logic [NCH-1:0]    w_cntNz;
  logic [NCH-1:0]    w_tick;
  logic [NCH-1:0]    w_raw;
  logic              r_freeQ;
  logic              w_halted;
  logic              w_allIdle;

  assign w_halted = (r_state == HALTED);

  // Per-channel hold counters, activity and enable generation. A request
  // always reloads the counter (no accumulation); otherwise the counter
  // counts down on its tick, which is every cycle for plain channels and
  // only bus cycles for bus-qualified ones. HALTED suppresses everything.
  always_comb begin
    w_cntNz = '0;
    w_tick  = '0;
    w_raw   = '0;
    o_clken = '0;
    for (int i = 0; i < NCH; i++) begin
      w_cntNext[i] = r_cnt[i];
      w_cntNz[i]   = |r_cnt[i];
      w_tick[i]    = BUS_QUAL[i] ? i_bus_clk_en : 1'b1;
      w_raw[i]     = ~w_halted & (i_req[i] | w_cntNz[i]);
      if (w_halted) begin
        w_cntNext[i] = '0;
      end else if (i_req[i]) begin
        w_cntNext[i] = i_hold_cfg[i*HOLD_W +: HOLD_W];
      end else if (w_cntNz[i] && w_tick[i]) begin
        w_cntNext[i] = r_cnt[i] - HOLD_W'(1);
      end
      if (BUS_QUAL[i]) begin
        o_clken[i] = i_scan_mode | ((i_clk_override | w_raw[i]) & i_bus_clk_en);
      end else begin
        o_clken[i] = i_scan_mode | i_clk_override | w_raw[i];
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NCH; i++) begin
        r_cnt[i] <= '0;
      end
    end else begin
      for (int i = 0; i < NCH; i++) begin
        r_cnt[i] <= w_cntNext[i];
      end
    end
  end

  // The free-running enable lingers one cycle after the last activity so
  // that the domain sees a clean trailing edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_freeQ <= 1'b0;
    end else begin
      r_freeQ <= |w_raw;
    end
  end

  // Drain completes only in a cycle with no request and every counter at
  // zero, so a request arriving during drain postpones the halt.
  assign w_allIdle = ~(|i_req) & ~(|w_cntNz);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= RUN;
    end else begin
      r_state <= w_stateNext;
    end
  end

  always_comb begin
    w_stateNext = r_state;
    case (r_state)
      RUN: begin
        if (i_halt_req) w_stateNext = DRAIN;
      end
      DRAIN: begin
        if (!i_halt_req)    w_stateNext = RUN;
        else if (w_allIdle) w_stateNext = HALTED;
      end
      HALTED: begin
        if (!i_halt_req) w_stateNext = RUN;
      end
      default: w_stateNext = RUN;
    endcase
  end

  assign o_halt_ack   = w_halted;
  assign o_ch_busy    = w_cntNz;
  assign o_free_clken = i_scan_mode | i_clk_override | (|w_raw) | r_freeQ;

endmodule
